// File: rtl/mem_pkg.sv
// Shared definitions for the memory responder slice.
// - Handshake FSM state encoding.
// - Default word/address widths and the wait-state counter width.
// - r_wbar encoding: RD = 1, WR = 0.
package mem_pkg;

  localparam int unsigned MEM_DATA_W = 16;
  localparam int unsigned MEM_ADDR_W = 5;
  // Wide enough for WAIT_STATES up to 15.
  localparam int unsigned CNT_W      = 4;

  localparam logic RD = 1'b1;
  localparam logic WR = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } mem_state_e;

endpackage

// File: rtl/mem_array.sv
// Single-port word store: synchronous write, registered read.
// Optional feature macro: MEM_PARITY_EN adds one even-parity bit per word,
// generated on write and checked on read.
// Ports:
//   clock  in   clock
//   we     in   write enable (word written at posedge)
//   re     in   read enable (rdata/rerr registered at posedge)
//   addr   in   word address; caller only enables for addr < DEPTH
//   wdata  in   write data
//   rdata  out  registered read data
//   rerr   out  registered parity mismatch flag (constant 0 without parity)
module mem_array
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W = MEM_DATA_W,
  parameter int unsigned ADDR_W = MEM_ADDR_W,
  parameter int unsigned DEPTH  = 32
) (
  input  logic              clock,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              rerr
);

`ifdef MEM_PARITY_EN
  // MSB of each entry holds the parity bit so the whole entry XORs to 0.
  logic [DATA_W:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= {^wdata, wdata};
    end
    if (re) begin
      rdata <= mem[addr][DATA_W-1:0];
      rerr  <= ^mem[addr];
    end
  end
`else
  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clock) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    if (re) begin
      rdata <= mem[addr];
    end
  end

  assign rerr = 1'b0;
`endif

endmodule

// File: rtl/memory_responder.sv
// Memory-side end of the execution unit's bus. Accepts one request at a time
// via req/ack, inserts WAIT_STATES cycles of latency, then performs the access
// on the word store and pulses ack for one cycle.
// Optional feature macro: MEM_PARITY_EN (parity-checked reads, see mem_array).
// Ports:
//   clock    in   single clock
//   reset_n  in   synchronous active-low reset
//   req      in   request, held until ack is seen
//   r_wbar   in   1 = read, 0 = write; sampled at accept
//   eab      in   word address; sampled at accept
//   edb_wr   in   write data; sampled at accept
//   edb_rd   out  read data, valid while ack = 1, otherwise 0
//   ack      out  one-cycle completion pulse
//   err      out  out-of-range / parity error, valid while ack = 1
//   busy     out  high whenever the FSM is not idle
module memory_responder
  import mem_pkg::*;
#(
  parameter int unsigned DATA_W      = MEM_DATA_W,
  parameter int unsigned ADDR_W      = MEM_ADDR_W,
  parameter int unsigned DEPTH       = 32,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req,
  input  logic              r_wbar,
  input  logic [ADDR_W-1:0] eab,
  input  logic [DATA_W-1:0] edb_wr,
  output logic [DATA_W-1:0] edb_rd,
  output logic              ack,
  output logic              err,
  output logic              busy
);

  // One extra bit so DEPTH == 2**ADDR_W is representable.
  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [CNT_W-1:0] WAIT_L  = CNT_W'(WAIT_STATES);

  mem_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] data_q;
  logic              rd_q;

  logic              in_range;
  logic              access;
  logic              we, re;
  logic [DATA_W-1:0] rdata;
  logic              rerr;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign access   = (state_q == WAIT) && (cnt_q == '0);
  // Gating with reset_n keeps a reset on the WAIT->RESP edge from committing.
  assign we       = reset_n && access && (rd_q == WR) && in_range;
  assign re       = reset_n && access && (rd_q == RD) && in_range;

  mem_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_mem_array (
    .clock (clock),
    .we    (we),
    .re    (re),
    .addr  (addr_q),
    .wdata (data_q),
    .rdata (rdata),
    .rerr  (rerr)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (req) state_d = WAIT;
      WAIT: if (cnt_q == '0) state_d = RESP;
      RESP: state_d = req ? HOLD : IDLE;
      HOLD: if (!req) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch and wait-state counter.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      addr_q <= '0;
      data_q <= '0;
      rd_q   <= RD;
    end else if ((state_q == IDLE) && req) begin
      cnt_q  <= WAIT_L;
      addr_q <= eab;
      data_q <= edb_wr;
      rd_q   <= r_wbar;
    end else if ((state_q == WAIT) && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Outputs. rerr is stale on writes, so it only counts for reads.
  always_comb begin
    ack    = (state_q == RESP);
    busy   = (state_q != IDLE);
    err    = ack && (!in_range || ((rd_q == RD) && rerr));
    edb_rd = '0;
    if (ack && (rd_q == RD) && in_range) begin
      edb_rd = rdata;
    end
  end

endmodule

// File: tb/tb_memory_responder.sv
module tb_memory_responder;

  localparam int unsigned DW    = 16;
  localparam int unsigned AW    = 5;
  localparam int unsigned DEPTH = 24;
  localparam int unsigned WS    = 3;

  logic          clock;
  logic          reset_n;
  logic          req;
  logic          r_wbar;
  logic [AW-1:0] eab;
  logic [DW-1:0] edb_wr;
  logic [DW-1:0] edb_rd;
  logic          ack;
  logic          err;
  logic          busy;

  memory_responder #(
    .DATA_W      (DW),
    .ADDR_W      (AW),
    .DEPTH       (DEPTH),
    .WAIT_STATES (WS)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .req     (req),
    .r_wbar  (r_wbar),
    .eab     (eab),
    .edb_wr  (edb_wr),
    .edb_rd  (edb_rd),
    .ack     (ack),
    .err     (err),
    .busy    (busy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_checks = 0;
  int n_pass   = 0;

  // Reference: plain word array plus a per-word "corrupted parity" flag.
  logic [DW-1:0] model_mem [32];
  bit            bad_par   [32];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // One full transaction; hold = extra cycles req stays high after ack.
  task automatic txn(input bit rd, input int a, input logic [DW-1:0] d, input int hold);
    int cyc;
    bit seen;
    bit busy_ok;
    bit oor;
    oor = (a >= DEPTH);
    @(negedge clock);
    r_wbar = rd;
    eab    = AW'(a);
    edb_wr = d;
    req    = 1'b1;
    cyc = 0; seen = 0; busy_ok = 1;
    while (!seen && cyc < 40) begin
      @(negedge clock);
      cyc++;
      // Inputs after accept must be ignored.
      if (cyc == 1) begin
        eab    = AW'($urandom);
        edb_wr = DW'($urandom);
        r_wbar = 1'($urandom);
      end
      if (ack) seen = 1;
      else if (!busy) busy_ok = 0;
    end
    check("ack_seen", 32'(seen), 32'd1);
    check("latency", cyc, WS + 2);
    check("busy_wait", 32'(busy_ok), 32'd1);
    check("err", 32'(err), 32'(oor || (rd && bad_par[a])));
    if (rd) begin
      check("rdata", 32'(edb_rd), oor ? 32'd0 : 32'(model_mem[a]));
    end else if (!oor) begin
      model_mem[a] = d;
      bad_par[a]   = 0;
    end
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clock);
        check("hold_ack", 32'(ack), 32'd0);
        check("hold_busy", 32'(busy), 32'd1);
      end
    end
    req = 1'b0;
    @(negedge clock);
    check("idle_busy", 32'(busy), 32'd0);
    check("idle_ack", 32'(ack), 32'd0);
    check("idle_rdata", 32'(edb_rd), 32'd0);
  endtask

  initial begin
    int seen_ack;
    reset_n = 1'b0;
    req     = 1'b0;
    r_wbar  = 1'b1;
    eab     = '0;
    edb_wr  = '0;
    for (int i = 0; i < 32; i++) begin
      model_mem[i] = '0;
      bad_par[i]   = 0;
    end
    repeat (3) @(negedge clock);
    check("rst_ack", 32'(ack), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rdata", 32'(edb_rd), 32'd0);
    reset_n = 1'b1;

    // Fill every implemented word so later reads have known contents.
    for (int i = 0; i < DEPTH; i++) txn(1'b0, i, DW'($urandom), 0);

    txn(1'b0, 3, 16'hBEEF, 0);
    txn(1'b1, 3, '0, 0);

    // Out of range: no write, err with ack, zero read data.
    txn(1'b0, 25, 16'h1234, 0);
    txn(1'b1, 25, '0, 0);
    for (int i = 0; i < DEPTH; i++) txn(1'b1, i, '0, 0);

    // Request held after ack: one ack only, back to idle after req drops.
    txn(1'b1, 3, '0, 5);

    // Reset while waiting on a write abandons it.
    txn(1'b0, 7, 16'h5555, 0);
    @(negedge clock);
    eab = 5'd7; edb_wr = 16'hAAAA; r_wbar = 1'b0; req = 1'b1;
    @(negedge clock);
    check("rst_mid_busy", 32'(busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clock);
    check("rst_mid_idle", 32'(busy), 32'd0);
    req = 1'b0;
    @(negedge clock);
    reset_n = 1'b1;
    seen_ack = 0;
    repeat (8) begin
      @(negedge clock);
      if (ack) seen_ack++;
    end
    check("rst_mid_noack", seen_ack, 0);
    txn(1'b1, 7, '0, 0);

    // Request arriving together with reset is not accepted.
    @(negedge clock);
    req = 1'b1; reset_n = 1'b0; eab = 5'd1; r_wbar = 1'b0;
    @(negedge clock);
    check("rst_req_busy", 32'(busy), 32'd0);
    req = 1'b0; reset_n = 1'b1;
    @(negedge clock);
    check("rst_req_idle", 32'(busy), 32'd0);
    txn(1'b1, 1, '0, 0);

`ifdef MEM_PARITY_EN
    txn(1'b0, 2, 16'h0F0F, 0);
    dut.u_mem_array.mem[2][0] = ~dut.u_mem_array.mem[2][0];
    model_mem[2] = 16'h0F0E;
    bad_par[2]   = 1;
    txn(1'b1, 2, '0, 0);
    txn(1'b0, 2, 16'h0F0F, 0);
`endif

    // Random traffic across the full address space.
    for (int n = 0; n < 150; n++) begin
      txn(1'($urandom), int'($urandom_range(0, 31)), DW'($urandom),
          ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 5)) : 0);
    end
    for (int i = 0; i < DEPTH; i++) txn(1'b1, i, '0, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
